// File: rtl/sync_debounce_edge_if.sv
// Bundles the data-path signals of sync_debounce_edge into one port.
// SYNC_DEB_GLITCH_CNT_EN adds the glitch_cnt_o member to both modports.
interface sync_debounce_edge_if #(
    parameter int CNT_W = 8
);
    logic             sync_sig_i;
    logic             clr_i;
    logic             level_o;
    logic             rise_o;
    logic             fall_o;
    logic             busy_o;
    logic [CNT_W-1:0] edge_cnt_o;
`ifdef SYNC_DEB_GLITCH_CNT_EN
    logic [CNT_W-1:0] glitch_cnt_o;

    modport master (
        output sync_sig_i, clr_i,
        input  level_o, rise_o, fall_o, busy_o, edge_cnt_o, glitch_cnt_o
    );
    modport slave (
        input  sync_sig_i, clr_i,
        output level_o, rise_o, fall_o, busy_o, edge_cnt_o, glitch_cnt_o
    );
`else
    modport master (
        output sync_sig_i, clr_i,
        input  level_o, rise_o, fall_o, busy_o, edge_cnt_o
    );
    modport slave (
        input  sync_sig_i, clr_i,
        output level_o, rise_o, fall_o, busy_o, edge_cnt_o
    );
`endif
endinterface

// File: rtl/sync_debounce_edge.sv
// Debounces a synchronised bit, emits rise/fall pulses and counts accepted rises.
// Optional macro SYNC_DEB_GLITCH_CNT_EN adds a saturating count of aborted qualifications.
module sync_debounce_edge #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input logic                 clk,
    input logic                 rstn,
    sync_debounce_edge_if.slave bus
);
    localparam int              STAB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        QUAL_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        QUAL_LOW  = 2'd3
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [STAB_W-1:0]   stab_r, stab_nxt_s;
    logic                accept_rise_s, accept_fall_s, abort_s;
    logic                level_nxt_s, busy_nxt_s;
    logic                level_r, rise_r, fall_r, busy_r;
    logic [CNT_W-1:0]    edge_cnt_r;

    // Clear takes priority, then a pending increment is applied on top, saturating.
    function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] cur,
                                                   input logic clr,
                                                   input logic inc);
        logic [CNT_W-1:0] base;
        base = clr ? {CNT_W{1'b0}} : cur;
        if (inc && (base != CNT_MAX)) begin
            return base + CNT_W'(1);
        end else begin
            return base;
        end
    endfunction

    // State and stability-counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE_LOW;
            stab_r  <= {STAB_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            stab_r  <= stab_nxt_s;
        end
    end

    // Next-state logic: the sample that completes the window is accepted on that same edge.
    always_comb begin
        state_nxt_s   = state_r;
        stab_nxt_s    = stab_r;
        accept_rise_s = 1'b0;
        accept_fall_s = 1'b0;
        abort_s       = 1'b0;
        case (state_r)
            IDLE_LOW: begin
                if (bus.sync_sig_i) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nxt_s   = IDLE_HIGH;
                        stab_nxt_s    = {STAB_W{1'b0}};
                        accept_rise_s = 1'b1;
                    end else begin
                        state_nxt_s = QUAL_HIGH;
                        stab_nxt_s  = STAB_W'(1);
                    end
                end else begin
                    stab_nxt_s = {STAB_W{1'b0}};
                end
            end
            QUAL_HIGH: begin
                if (!bus.sync_sig_i) begin
                    state_nxt_s = IDLE_LOW;
                    stab_nxt_s  = {STAB_W{1'b0}};
                    abort_s     = 1'b1;
                end else if (stab_r == STAB_LAST) begin
                    state_nxt_s   = IDLE_HIGH;
                    stab_nxt_s    = {STAB_W{1'b0}};
                    accept_rise_s = 1'b1;
                end else begin
                    stab_nxt_s = stab_r + STAB_W'(1);
                end
            end
            IDLE_HIGH: begin
                if (!bus.sync_sig_i) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nxt_s   = IDLE_LOW;
                        stab_nxt_s    = {STAB_W{1'b0}};
                        accept_fall_s = 1'b1;
                    end else begin
                        state_nxt_s = QUAL_LOW;
                        stab_nxt_s  = STAB_W'(1);
                    end
                end else begin
                    stab_nxt_s = {STAB_W{1'b0}};
                end
            end
            QUAL_LOW: begin
                if (bus.sync_sig_i) begin
                    state_nxt_s = IDLE_HIGH;
                    stab_nxt_s  = {STAB_W{1'b0}};
                    abort_s     = 1'b1;
                end else if (stab_r == STAB_LAST) begin
                    state_nxt_s   = IDLE_LOW;
                    stab_nxt_s    = {STAB_W{1'b0}};
                    accept_fall_s = 1'b1;
                end else begin
                    stab_nxt_s = stab_r + STAB_W'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE_LOW;
                stab_nxt_s  = {STAB_W{1'b0}};
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with the state.
    always_comb begin
        level_nxt_s = 1'b0;
        busy_nxt_s  = 1'b0;
        case (state_nxt_s)
            IDLE_LOW:  begin level_nxt_s = 1'b0; busy_nxt_s = 1'b0; end
            QUAL_HIGH: begin level_nxt_s = 1'b0; busy_nxt_s = 1'b1; end
            IDLE_HIGH: begin level_nxt_s = 1'b1; busy_nxt_s = 1'b0; end
            QUAL_LOW:  begin level_nxt_s = 1'b1; busy_nxt_s = 1'b1; end
            default:   begin level_nxt_s = 1'b0; busy_nxt_s = 1'b0; end
        endcase
    end

    // Registered outputs and the rising-edge event counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level_r    <= 1'b0;
            rise_r     <= 1'b0;
            fall_r     <= 1'b0;
            busy_r     <= 1'b0;
            edge_cnt_r <= {CNT_W{1'b0}};
        end else begin
            level_r    <= level_nxt_s;
            rise_r     <= accept_rise_s;
            fall_r     <= accept_fall_s;
            busy_r     <= busy_nxt_s;
            edge_cnt_r <= sat_count(edge_cnt_r, bus.clr_i, accept_rise_s);
        end
    end

    assign bus.level_o    = level_r;
    assign bus.rise_o     = rise_r;
    assign bus.fall_o     = fall_r;
    assign bus.busy_o     = busy_r;
    assign bus.edge_cnt_o = edge_cnt_r;

`ifdef SYNC_DEB_GLITCH_CNT_EN
    logic [CNT_W-1:0] glitch_cnt_r;

    // Counts qualifications abandoned before the window completed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            glitch_cnt_r <= {CNT_W{1'b0}};
        end else begin
            glitch_cnt_r <= sat_count(glitch_cnt_r, bus.clr_i, abort_s);
        end
    end

    assign bus.glitch_cnt_o = glitch_cnt_r;
`else
    logic unused_abort_s;
    assign unused_abort_s = abort_s;
`endif
endmodule

// File: tb/tb_sync_debounce_edge.sv
// Directed, table-driven bench for sync_debounce_edge (DEBOUNCE_CYCLES=4, CNT_W=2)
// with a DEBOUNCE_CYCLES=1 companion instance sharing the same inputs.
module tb_sync_debounce_edge;
    logic clk;
    logic rstn;

    sync_debounce_edge_if #(.CNT_W(2)) bus ();
    sync_debounce_edge_if #(.CNT_W(8)) bus1 ();

    sync_debounce_edge #(.DEBOUNCE_CYCLES(4), .CNT_W(2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    sync_debounce_edge #(.DEBOUNCE_CYCLES(1), .CNT_W(8)) dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1)
    );

    assign bus1.sync_sig_i = bus.sync_sig_i;
    assign bus1.clr_i      = bus.clr_i;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic sig;
        logic clr;
        logic lvl;
        logic rise;
        logic fall;
        logic busy;
        int   cnt;
        int   gl;
    } vec_t;

    vec_t vq[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic add(input logic s, input logic c, input logic l, input logic r,
                       input logic f, input logic b, input int cnt, input int gl);
        vec_t v;
        v.sig = s; v.clr = c; v.lvl = l; v.rise = r; v.fall = f; v.busy = b;
        v.cnt = cnt; v.gl = gl;
        vq.push_back(v);
    endtask

    task automatic step(input logic s, input logic c);
        bus.sync_sig_i = s;
        bus.clr_i      = c;
        @(posedge clk);
        #1;
    endtask

    function automatic int all_out();
        return {27'd0, bus.level_o, bus.rise_o, bus.fall_o, bus.busy_o, 1'b0}
               | int'(bus.edge_cnt_o) << 8;
    endfunction

    initial begin
        logic prev_sig;

        // sig, clr -> level, rise, fall, busy, edge_cnt, glitch_cnt (after the edge)
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
        // glitch while low: three highs then abort
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1);
        add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1);
        // glitch while high, then toggling every cycle
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 2);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2, 2);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 3);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2, 3);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 3);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2, 3);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2, 3);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2, 3);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 3);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

        // reset held with toggling input
        rstn = 1'b0;
        bus.sync_sig_i = 1'b0;
        bus.clr_i      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'(i % 2), 1'b0);
            chk("reset_hold_outputs", all_out(), 0);
        end
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            chk("post_reset_idle", all_out(), 0);
        end

        // table-driven main sequence
        prev_sig = 1'b0;
        foreach (vq[i]) begin
            step(vq[i].sig, vq[i].clr);
            chk($sformatf("v%0d_level", i), int'(bus.level_o), int'(vq[i].lvl));
            chk($sformatf("v%0d_rise",  i), int'(bus.rise_o),  int'(vq[i].rise));
            chk($sformatf("v%0d_fall",  i), int'(bus.fall_o),  int'(vq[i].fall));
            chk($sformatf("v%0d_busy",  i), int'(bus.busy_o),  int'(vq[i].busy));
            chk($sformatf("v%0d_cnt",   i), int'(bus.edge_cnt_o), vq[i].cnt);
`ifdef SYNC_DEB_GLITCH_CNT_EN
            chk($sformatf("v%0d_glitch", i), int'(bus.glitch_cnt_o), vq[i].gl);
`endif
            chk($sformatf("v%0d_d1_level", i), int'(bus1.level_o), int'(vq[i].sig));
            chk($sformatf("v%0d_d1_rise", i), int'(bus1.rise_o), int'(vq[i].sig & ~prev_sig));
            chk($sformatf("v%0d_d1_fall", i), int'(bus1.fall_o), int'(~vq[i].sig & prev_sig));
            prev_sig = vq[i].sig;
        end

        // saturation of a 2-bit counter over five rises
        for (int n = 1; n <= 5; n++) begin
            for (int j = 0; j < 3; j++) step(1'b1, 1'b0);
            step(1'b1, 1'b0);
            chk($sformatf("sat_rise%0d_pulse", n), int'(bus.rise_o), 1);
            chk($sformatf("sat_rise%0d_cnt", n), int'(bus.edge_cnt_o), (n > 3) ? 3 : n);
            for (int j = 0; j < 3; j++) step(1'b0, 1'b0);
            step(1'b0, 1'b0);
            chk($sformatf("sat_fall%0d_pulse", n), int'(bus.fall_o), 1);
        end
        // sixth acceptance coincident with clear
        for (int j = 0; j < 3; j++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("clr_with_rise_cnt", int'(bus.edge_cnt_o), 1);
        chk("clr_with_rise_pulse", int'(bus.rise_o), 1);
        step(1'b1, 1'b0);
        chk("after_clr_rise_cnt", int'(bus.edge_cnt_o), 1);
        chk("after_clr_rise_pulse", int'(bus.rise_o), 0);
        for (int j = 0; j < 4; j++) step(1'b0, 1'b0);
        chk("back_low_level", int'(bus.level_o), 0);

        // reset in the middle of qualifying a rise
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("midq_busy", int'(bus.busy_o), 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("midq_reset_immediate", all_out(), 0);
        @(posedge clk);
        #1;
        chk("midq_reset_held", all_out(), 0);
        rstn = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step(1'b1, 1'b0);
            chk($sformatf("midq_rel_s%0d_rise", j), int'(bus.rise_o), 0);
            chk($sformatf("midq_rel_s%0d_busy", j), int'(bus.busy_o), 1);
        end
        step(1'b1, 1'b0);
        chk("midq_rel_rise", int'(bus.rise_o), 1);
        chk("midq_rel_level", int'(bus.level_o), 1);
        chk("midq_rel_cnt", int'(bus.edge_cnt_o), 1);
        step(1'b1, 1'b0);
        chk("midq_rel_rise_done", int'(bus.rise_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sync_debounce_edge.md
Name: sync_debounce_edge

Overview:
- Consumes the single-bit output of the two-flop synchroniser, already in the `clk` domain.
- Qualifies it with a stability (debounce) window.
- Produces a clean level, single-cycle rise/fall pulses and a saturating count of qualified rising edges.
- Sits directly downstream of the synchroniser; feeds control logic that needs one event per real transition.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive equal samples needed to accept a new level; legal range >= 1.
- CNT_W, 8, width of the rising-edge event counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- sync_sig_i  input  1  synchronised signal, driven from the synchroniser's `sync_sig_o`.
- clr_i  input  1  synchronous clear of the event counter(s), active high.
- level_o  output  1  debounced level.
- rise_o  output  1  one-cycle pulse on an accepted 0->1 transition.
- fall_o  output  1  one-cycle pulse on an accepted 1->0 transition.
- busy_o  output  1  high while a candidate transition is being qualified.
- edge_cnt_o  output  CNT_W  number of accepted rising edges, saturating.

Behaviour:
- Reset, asynchronous, effective immediately when rstn=0:
  - state = IDLE_LOW
  - stability counter = 0
  - level_o = 0, rise_o = 0, fall_o = 0, busy_o = 0, edge_cnt_o = 0
- Stability counter width: clog2(DEBOUNCE_CYCLES+1).
- States: IDLE_LOW, QUAL_HIGH, IDLE_HIGH, QUAL_LOW.
- IDLE_LOW:
  - sync_sig_i=1 moves to QUAL_HIGH with counter=1.
  - If DEBOUNCE_CYCLES=1, the transition is accepted on that same edge and the state goes straight to IDLE_HIGH.
- QUAL_HIGH:
  - sync_sig_i=0 aborts: return to IDLE_LOW, counter=0, no pulse.
  - Otherwise the counter increments.
  - When the DEBOUNCE_CYCLES-th consecutive high sample is taken, the state goes to IDLE_HIGH.
- IDLE_HIGH and QUAL_LOW: mirror of the above with polarity inverted.
- Acceptance edge:
  - The first high sample is taken at edge k.
  - The rise is accepted at edge k+DEBOUNCE_CYCLES-1.
  - After that edge: level_o=1, rise_o=1 for exactly one cycle, and edge_cnt_o increments.
- Fall acceptance: same timing as a rise, with fall_o pulsing instead; edge_cnt_o does not change.
- busy_o: high in QUAL_HIGH and QUAL_LOW, low otherwise.
- level_o changes only on accepted transitions.
- rise_o and fall_o are never high in the same cycle.
- edge_cnt_o:
  - Saturates at 2^CNT_W-1; further rises still pulse rise_o.
  - clr_i=1 clears it on the next edge.
  - clr_i coincident with an accepted rise gives edge_cnt_o = 1 (clear first, then count).
- Reset mid-qualification: the candidate is discarded and no pulse is issued.
- After reset release with sync_sig_i already 1: qualification starts normally and a rise is reported once the window completes.
- Input toggling every cycle: never accepted while DEBOUNCE_CYCLES >= 2.

Optional Feature:
- Macro: SYNC_DEB_GLITCH_CNT_EN.
- Defined:
  - Adds output glitch_cnt_o, width CNT_W, reset value 0.
  - Increments on every aborted qualification (QUAL_HIGH->IDLE_LOW or QUAL_LOW->IDLE_HIGH).
  - Saturating.
  - Cleared by clr_i with the same clear-then-count priority as edge_cnt_o.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset: hold rstn=0 with sync_sig_i toggling -> all outputs 0; release with input 0 for 10 cycles -> outputs stay 0.
- Clean rise (DEBOUNCE_CYCLES=4): input 1 from edge k, held 10 cycles -> level_o=1 and rise_o=1 after edge k+3; rise_o low again after edge k+4; edge_cnt_o=1; busy_o high after edges k..k+2.
- Glitch: input 1 for 3 cycles then 0 -> level_o=0, no rise_o, edge_cnt_o=0; glitch_cnt_o=1 when SYNC_DEB_GLITCH_CNT_EN is defined.
- Fall: from level_o=1, input 0 held 4 cycles -> fall_o pulses once after the 4th low sample; level_o=0; edge_cnt_o unchanged.
- Saturation/clear (CNT_W=2): 5 qualified rises -> edge_cnt_o=3 and held; clr_i asserted in the same cycle as the 6th acceptance -> edge_cnt_o=1.
- Reset mid-qualification: rstn=0 after 2 high samples -> outputs 0 immediately, no rise_o; release with input still 1 -> rise_o after 4 further samples.
